// File: rtl/tcm_arbiter_pkg.sv
// Shared types and bus-width macros for the two-master TCM arbiter.
// The macros fall back to the femto defaults when no platform header defined them first.
`ifndef TCM_VA_WIDTH
`define TCM_VA_WIDTH 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

package tcm_arbiter_pkg;

    // Which master, if any, has an accepted request waiting for its response.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_I = 2'b01,
        WAIT_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [`TCM_VA_WIDTH-1:0]  addr;
        logic                      w_rb;
        logic [`BUS_ACC_WIDTH-1:0] acc;
        logic [`BUS_WIDTH-1:0]     wdata;
    } bus_req_t;

endpackage

// File: rtl/tcm_arbiter_rr_pick2.sv
// Two-way picker: round-robin against the last grant when RR != 0, otherwise dbus always wins.
module tcm_arbiter_rr_pick2
    import tcm_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last,
    output logic   gnt_valid,
    output grant_t gnt
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt_valid = req_i | req_d;
        gnt       = GNT_D;
        if (req_i && req_d) begin
            gnt = (RR != 0 && last == GNT_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/tcm_arbiter.sv
// Arbitrates the ibus and dbus masters onto one TCM controller port. Requests are held by
// the masters; fault comes back in the issue cycle, resp/rdata exactly one cycle later.
module tcm_arbiter
    import tcm_arbiter_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [`TCM_VA_WIDTH-1:0]  i_addr,
    input  logic                      i_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
    input  logic [`BUS_WIDTH-1:0]     i_wdata,
    input  logic                      i_req,
    output logic [`BUS_WIDTH-1:0]     i_rdata,
    output logic                      i_resp,
    output logic                      i_fault,

    input  logic [`TCM_VA_WIDTH-1:0]  d_addr,
    input  logic                      d_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] d_acc,
    input  logic [`BUS_WIDTH-1:0]     d_wdata,
    input  logic                      d_req,
    output logic [`BUS_WIDTH-1:0]     d_rdata,
    output logic                      d_resp,
    output logic                      d_fault,

    output logic [`TCM_VA_WIDTH-1:0]  s_addr,
    output logic                      s_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] s_acc,
    output logic [`BUS_WIDTH-1:0]     s_wdata,
    output logic                      s_req,
    input  logic [`BUS_WIDTH-1:0]     s_rdata,
    input  logic                      s_resp,
    input  logic                      s_fault
);

    arb_state_t state, state_nxt;
    grant_t     last_gnt, gnt;
    bus_req_t   i_bus, d_bus, win_bus, s_hold;
    logic       cand_i, cand_d, can_issue, gnt_valid, issue;

    assign i_bus = '{addr: i_addr, w_rb: i_w_rb, acc: i_acc, wdata: i_wdata};
    assign d_bus = '{addr: d_addr, w_rb: d_w_rb, acc: d_acc, wdata: d_wdata};

    // A master still waiting for its response keeps req high; it must not be issued twice.
    assign cand_i    = i_req && (state != WAIT_I);
    assign cand_d    = d_req && (state != WAIT_D);
    assign can_issue = (state == IDLE) || s_resp;

    tcm_arbiter_rr_pick2 #(
        .RR (RR)
    ) u_pick (
        .req_i     (cand_i),
        .req_d     (cand_d),
        .last      (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign issue   = can_issue && gnt_valid && !rst;
    assign win_bus = (gnt == GNT_D) ? d_bus : i_bus;

    assign s_req = issue;
    assign {s_addr, s_w_rb, s_acc, s_wdata} = issue ? win_bus : s_hold;

    // Read data is shared and only meaningful while the matching resp is high.
    assign i_rdata = s_rdata;
    assign d_rdata = s_rdata;

    always_comb begin
        state_nxt = state;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_fault   = 1'b0;
        d_fault   = 1'b0;

        unique case (state)
            WAIT_I: if (s_resp) begin
                i_resp    = 1'b1;
                state_nxt = IDLE;
            end
            WAIT_D: if (s_resp) begin
                d_resp    = 1'b1;
                state_nxt = IDLE;
            end
            default: ;
        endcase

        if (issue) begin
            if (s_fault) begin
                if (gnt == GNT_D) d_fault = 1'b1;
                else              i_fault = 1'b1;
                state_nxt = IDLE;
            end else begin
                state_nxt = (gnt == GNT_D) ? WAIT_D : WAIT_I;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= GNT_D;
            s_hold   <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                last_gnt <= gnt;
                s_hold   <= win_bus;
            end
        end
    end

endmodule

// File: tb/tb_tcm_arbiter.sv
// Self-checking bench: a round-robin instance driven by scoreboarded masters and a fixed-priority
// instance checked against a small arbitration model, each with its own one-cycle TCM slave.
`ifndef TCM_VA_WIDTH
`define TCM_VA_WIDTH 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_tcm_arbiter;

    localparam int AW = `TCM_VA_WIDTH;
    localparam int DW = `BUS_WIDTH;
    localparam int CW = `BUS_ACC_WIDTH;
    localparam logic [AW-1:0] FX_I_ADDR = AW'('h40);
    localparam logic [AW-1:0] FX_D_ADDR = AW'('h80);

    typedef struct {
        logic          fault;
        logic          rd;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic misal(input logic [AW-1:0] a, input logic [CW-1:0] acc);
        case (acc)
            `BUS_ACC_1B: return 1'b0;
            `BUS_ACC_2B: return a[0];
            `BUS_ACC_4B: return a[1:0] != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a) & 32'hFFFF_FFFC;
        return DW'((w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // ---------------- round-robin instance ----------------
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic          i_w_rb = 1'b0, d_w_rb = 1'b0;
    logic [CW-1:0] i_acc = '0, d_acc = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0;
    logic          i_req = 1'b0, d_req = 1'b0;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_resp, d_resp, i_fault, d_fault;
    logic [AW-1:0] s_addr;
    logic          s_w_rb;
    logic [CW-1:0] s_acc;
    logic [DW-1:0] s_wdata;
    logic          s_req;
    logic [DW-1:0] s_rdata;
    logic          s_resp, s_fault;
    logic          inj_resp = 1'b0;
    logic          slv_resp_q = 1'b0;
    logic [DW-1:0] slv_rdata_q = '0;

    tcm_arbiter #(.RR(1)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata), .i_req(i_req),
        .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
        .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
        .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata), .s_req(s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    assign s_fault = s_req && misal(s_addr, s_acc);
    assign s_resp  = slv_resp_q | inj_resp;
    assign s_rdata = slv_rdata_q;
    always @(posedge clk) begin
        slv_resp_q  <= s_req && !s_fault;
        slv_rdata_q <= mem_word(s_addr);
    end

    // ---------------- fixed-priority instance ----------------
    logic          f_i_req = 1'b0, f_d_req = 1'b0;
    logic [DW-1:0] f_i_rdata, f_d_rdata;
    logic          f_i_resp, f_d_resp, f_i_fault, f_d_fault;
    logic [AW-1:0] f_s_addr;
    logic          f_s_w_rb;
    logic [CW-1:0] f_s_acc;
    logic [DW-1:0] f_s_wdata;
    logic          f_s_req;
    logic          f_slv_resp_q = 1'b0;
    logic [DW-1:0] f_slv_rdata_q = '0;
    logic          f_s_fault;

    tcm_arbiter #(.RR(0)) dut_fx (
        .clk(clk), .rst(rst),
        .i_addr(FX_I_ADDR), .i_w_rb(1'b0), .i_acc(`BUS_ACC_4B), .i_wdata('0), .i_req(f_i_req),
        .i_rdata(f_i_rdata), .i_resp(f_i_resp), .i_fault(f_i_fault),
        .d_addr(FX_D_ADDR), .d_w_rb(1'b0), .d_acc(`BUS_ACC_4B), .d_wdata('0), .d_req(f_d_req),
        .d_rdata(f_d_rdata), .d_resp(f_d_resp), .d_fault(f_d_fault),
        .s_addr(f_s_addr), .s_w_rb(f_s_w_rb), .s_acc(f_s_acc), .s_wdata(f_s_wdata), .s_req(f_s_req),
        .s_rdata(f_slv_rdata_q), .s_resp(f_slv_resp_q), .s_fault(f_s_fault)
    );

    assign f_s_fault = f_s_req && misal(f_s_addr, f_s_acc);
    always @(posedge clk) begin
        f_slv_resp_q  <= f_s_req && !f_s_fault;
        f_slv_rdata_q <= mem_word(f_s_addr);
    end

    // ---------------- scoreboard ----------------
    exp_t q_i[$];
    exp_t q_d[$];
    exp_t mi, md;

    always @(negedge clk) begin
        if (!rst) begin
            if (i_resp || i_fault) begin
                check("i_resp_and_fault", 64'(i_resp & i_fault), 64'(0));
                if (q_i.size() == 0) begin
                    check("i_unexpected_completion", 64'(q_i.size()), 64'(1));
                end else begin
                    mi = q_i.pop_front();
                    check("i_fault_kind", 64'(i_fault), 64'(mi.fault));
                    if (!mi.fault && mi.rd) check("i_rdata", 64'(i_rdata), 64'(mi.rdata));
                end
            end
            if (d_resp || d_fault) begin
                check("d_resp_and_fault", 64'(d_resp & d_fault), 64'(0));
                if (q_d.size() == 0) begin
                    check("d_unexpected_completion", 64'(q_d.size()), 64'(1));
                end else begin
                    md = q_d.pop_front();
                    check("d_fault_kind", 64'(d_fault), 64'(md.fault));
                    if (!md.fault && md.rd) check("d_rdata", 64'(d_rdata), 64'(md.rdata));
                end
            end
        end
    end

    task automatic drive(input bit is_d, input logic [AW-1:0] a, input logic [CW-1:0] acc,
                         input logic wrb, input logic [DW-1:0] wd);
        exp_t e;
        e.fault = misal(a, acc);
        e.rd    = !wrb;
        e.rdata = mem_word(a);
        if (is_d) begin
            d_addr = a; d_acc = acc; d_w_rb = wrb; d_wdata = wd; d_req = 1'b1;
            q_d.push_back(e);
        end else begin
            i_addr = a; i_acc = acc; i_w_rb = wrb; i_wdata = wd; i_req = 1'b1;
            q_i.push_back(e);
        end
    endtask

    task automatic wait_done(input bit is_d, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            done = is_d ? (d_resp || d_fault) : (i_resp || i_fault);
        end
        if (!done) check(is_d ? "d_timeout" : "i_timeout", 64'(done), 64'(1));
        @(posedge clk);
        #1;
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic run_master(input bit is_d, input int n);
        logic [AW-1:0] a;
        logic [CW-1:0] acc;
        int            g;
        for (int t = 0; t < n; t++) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
            acc = CW'($urandom_range(0, 2));
            a   = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~AW'((1 << acc) - 1);
            drive(is_d, a, acc, 1'($urandom_range(0, 1)), DW'($urandom));
            wait_done(is_d, 20);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fx_out;
        logic fx_cand_i, fx_cand_d;
        int fx_win;

        // Reset state: outputs quiet, and a pending (even faulting) request is not issued.
        #1 rst = 1'b1;
        #2;
        check("rst_s_req", 64'(s_req), 64'(0));
        check("rst_resp", 64'({i_resp, d_resp}), 64'(0));
        i_addr = AW'('h1); i_acc = `BUS_ACC_4B; i_req = 1'b1;
        #1;
        check("rst_gate_s_req", 64'(s_req), 64'(0));
        check("rst_gate_fault", 64'({i_fault, d_fault}), 64'(0));
        i_req = 1'b0;
        do_reset();

        // Single ibus 4B read: issued in cycle 0, resp and rdata in cycle 1, fields held after.
        drive(1'b0, AW'('h10), `BUS_ACC_4B, 1'b0, '0);
        #1;
        check("t1_s_req_c0", 64'(s_req), 64'(1));
        check("t1_s_addr_c0", 64'(s_addr), 64'('h10));
        @(negedge clk);
        check("t1_no_resp_c0", 64'(i_resp), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_i_resp_c1", 64'(i_resp), 64'(1));
        check("t1_i_rdata_c1", 64'(i_rdata), 64'(mem_word(AW'('h10))));
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        check("t1_idle_s_req", 64'(s_req), 64'(0));
        check("t1_hold_s_addr", 64'(s_addr), 64'('h10));
        check("t1_single_resp", 64'(i_resp), 64'(0));

        // Both masters after reset: ibus first, dbus issued in ibus's resp cycle.
        do_reset();
        drive(1'b0, AW'('h20), `BUS_ACC_4B, 1'b0, '0);
        drive(1'b1, AW'('h30), `BUS_ACC_4B, 1'b0, '0);
        @(negedge clk);
        check("t2_first_grant_i", 64'(s_addr), 64'('h20));
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_i_resp", 64'(i_resp), 64'(1));
        check("t2_d_issue_in_i_resp", 64'(s_req), 64'(1));
        check("t2_d_issue_addr", 64'(s_addr), 64'('h30));
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        check("t2_d_resp", 64'(d_resp), 64'(1));
        check("t2_no_reissue_d", 64'(s_req), 64'(0));
        @(posedge clk); #1 d_req = 1'b0;

        // Misaligned dbus 2B write faults in the issue cycle; the next request goes out straight away.
        drive(1'b1, AW'('h3), `BUS_ACC_2B, 1'b1, DW'('hCAFE));
        @(negedge clk);
        check("t3_d_fault", 64'(d_fault), 64'(1));
        check("t3_no_d_resp", 64'(d_resp), 64'(0));
        check("t3_s_wdata", 64'(s_wdata), 64'('hCAFE));
        check("t3_s_w_rb", 64'(s_w_rb), 64'(1));
        @(posedge clk); #1 d_req = 1'b0;
        drive(1'b0, AW'('h44), `BUS_ACC_4B, 1'b0, '0);
        @(negedge clk);
        check("t3_next_issue", 64'(s_req), 64'(1));
        check("t3_next_addr", 64'(s_addr), 64'('h44));
        check("t3_no_late_d_resp", 64'(d_resp), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_i_resp", 64'(i_resp), 64'(1));
        @(posedge clk); #1 i_req = 1'b0;

        // Reset pulsed while waiting on dbus: outputs drop at once, the late s_resp is ignored.
        drive(1'b1, AW'('h24), `BUS_ACC_4B, 1'b0, '0);
        @(negedge clk);
        check("t5_issue", 64'(s_req), 64'(1));
        @(posedge clk); #1;
        check("t5_d_resp_before_rst", 64'(d_resp), 64'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_d_resp", 64'(d_resp), 64'(0));
        check("t5_rst_s_req", 64'(s_req), 64'(0));
        check("t5_rst_faults", 64'({i_fault, d_fault, i_resp}), 64'(0));
        d_req = 1'b0;
        q_d.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_late_resp_dropped", 64'(d_resp), 64'(0));
        check("t5_late_resp_no_i", 64'(i_resp), 64'(0));
        @(posedge clk); #1;

        // Spurious s_resp while idle.
        inj_resp = 1'b1;
        @(negedge clk);
        check("t6_spurious_i", 64'(i_resp), 64'(0));
        check("t6_spurious_d", 64'(d_resp), 64'(0));
        @(posedge clk); #1 inj_resp = 1'b0;

        // Random concurrent traffic against the scoreboard.
        fork
            run_master(1'b0, 12);
            run_master(1'b1, 12);
        join
        repeat (3) @(posedge clk);
        #1;
        check("sb_i_drained", 64'(q_i.size()), 64'(0));
        check("sb_d_drained", 64'(q_d.size()), 64'(0));

        // Fixed priority: dbus wins whenever it is a candidate.
        do_reset();
        f_i_req = 1'b1;
        f_d_req = 1'b1;
        fx_out  = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            fx_cand_d = f_d_req && fx_out != 2;
            fx_cand_i = f_i_req && fx_out != 1;
            fx_win    = fx_cand_d ? 2 : (fx_cand_i ? 1 : 0);
            check("fx_s_req", 64'(f_s_req), 64'(fx_win != 0));
            if (fx_win != 0) check("fx_grant_addr", 64'(f_s_addr), 64'(fx_win == 2 ? FX_D_ADDR : FX_I_ADDR));
            check("fx_d_resp", 64'(f_d_resp), 64'(fx_out == 2));
            check("fx_i_resp", 64'(f_i_resp), 64'(fx_out == 1));
            if (fx_out == 2) check("fx_d_rdata", 64'(f_d_rdata), 64'(mem_word(FX_D_ADDR)));
            fx_out = fx_win;
            @(posedge clk);
            #1;
            f_d_req = !(c >= 7 && c < 10);
        end
        f_i_req = 1'b0;
        f_d_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
